// File: rtl/pipeline_sequencer.sv
// Central pipeline sequencer: owns per-latch enable/flush, run/step/halt modes,
// halt drain and saturating advance/stall counters for an N-stage pipeline.
module pipeline_sequencer #(
    parameter int NUM_STAGES  = 5,
    parameter int STALL_LATCH = 1,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_BITS    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_step_req,
    input  logic [CNT_BITS-1:0]   i_step_count,
    input  logic                  i_stop,
    input  logic                  i_stall,
    input  logic                  i_taken,
    input  logic                  i_halt_detect,
    output logic                  o_pc_en,
    output logic [NUM_STAGES-2:0] o_latch_en,
    output logic [NUM_STAGES-2:0] o_latch_flush,
    output logic                  o_busy,
    output logic                  o_halted,
    output logic [CNT_BITS-1:0]   o_cycle_count,
    output logic [CNT_BITS-1:0]   o_stall_count,
    output logic [2:0]            o_dbg_state
);

    localparam int NL = NUM_STAGES - 1;
    localparam int DW = $clog2(NUM_STAGES) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    // Mask with bits [n-1:0] set, clipped to the latch count.
    function automatic logic [NL-1:0] below_mask(input int n);
        logic [NL-1:0] m;
        m = '0;
        for (int i = 0; i < NL; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    localparam logic [NL-1:0] ALL_MASK    = '1;
    localparam logic [NL-1:0] HOLD_MASK   = below_mask(STALL_LATCH);
    localparam logic [NL-1:0] BUBBLE_MASK = below_mask(STALL_LATCH + 1) & ~HOLD_MASK;
    localparam logic [NL-1:0] REDIR_MASK  = below_mask(FLUSH_DEPTH);
    localparam logic [NL-1:0] DRAIN_MASK  = below_mask(1);

    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [DW-1:0]       DRAIN_LEN = DW'(NL);
    localparam logic [DW-1:0]       DRAIN_ONE = DW'(1);

    state_t              r_state;
    logic [CNT_BITS-1:0] r_step_rem;
    logic [DW-1:0]       r_drain_rem;
    logic                r_saved_step;
    logic [CNT_BITS-1:0] r_cycle_cnt;
    logic [CNT_BITS-1:0] r_stall_cnt;

    state_t              w_state_nxt;
    logic [CNT_BITS-1:0] w_step_rem_nxt;
    logic [DW-1:0]       w_drain_rem_nxt;
    logic                w_saved_step_nxt;
    logic                w_advance;
    logic                w_redirect;
    logic                w_stall_cyc;

    // i_start / i_step_req / i_stop are single-cycle pulses with no handshake;
    // start and step requests are only looked at while IDLE.
    always_comb begin
        w_advance   = (r_state == S_DRAIN) ||
                      (((r_state == S_RUN) || (r_state == S_STEP)) && !i_stop);
        w_redirect  = w_advance && i_taken;
        w_stall_cyc = w_advance && !i_taken && i_stall && (r_state != S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_step_rem   <= CNT_ZERO;
            r_drain_rem  <= '0;
            r_saved_step <= 1'b0;
            r_cycle_cnt  <= CNT_ZERO;
            r_stall_cnt  <= CNT_ZERO;
        end else begin
            r_state      <= w_state_nxt;
            r_step_rem   <= w_step_rem_nxt;
            r_drain_rem  <= w_drain_rem_nxt;
            r_saved_step <= w_saved_step_nxt;
            if (w_advance && (r_cycle_cnt != CNT_MAX)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            end
            if (w_stall_cyc && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_step_rem_nxt   = r_step_rem;
        w_drain_rem_nxt  = r_drain_rem;
        w_saved_step_nxt = r_saved_step;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end else if (i_step_req) begin
                    w_state_nxt    = S_STEP;
                    w_step_rem_nxt = (i_step_count == CNT_ZERO) ? CNT_ONE : i_step_count;
                end
            end
            S_RUN, S_STEP: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    if (r_state == S_STEP) begin
                        w_step_rem_nxt = r_step_rem - CNT_ONE;
                    end
                    // A halt is only accepted on a plain advance cycle.
                    if (!i_taken && !i_stall && i_halt_detect) begin
                        w_state_nxt      = S_DRAIN;
                        w_drain_rem_nxt  = DRAIN_LEN;
                        w_saved_step_nxt = (r_state == S_STEP);
                    end else if ((r_state == S_STEP) && (r_step_rem == CNT_ONE)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (i_taken) begin
                    // Halt was on the wrong path: resume the interrupted mode.
                    if (!r_saved_step) begin
                        w_state_nxt = S_RUN;
                    end else if (r_step_rem == CNT_ZERO) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_STEP;
                    end
                end else begin
                    w_drain_rem_nxt = r_drain_rem - DRAIN_ONE;
                    if (r_drain_rem == DRAIN_ONE) begin
                        w_state_nxt = S_HALTED;
                    end
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_pc_en       = 1'b0;
        o_latch_en    = '0;
        o_latch_flush = '0;
        o_busy        = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
        o_halted      = (r_state == S_HALTED);
        if (w_redirect) begin
            o_pc_en       = 1'b1;
            o_latch_en    = ALL_MASK;
            o_latch_flush = REDIR_MASK;
        end else if (r_state == S_DRAIN) begin
            o_latch_en    = ALL_MASK;
            o_latch_flush = DRAIN_MASK;
        end else if (w_stall_cyc) begin
            o_latch_en    = ALL_MASK & ~HOLD_MASK;
            o_latch_flush = BUBBLE_MASK;
        end else if (w_advance) begin
            o_pc_en    = 1'b1;
            o_latch_en = ALL_MASK;
        end
    end

    assign o_cycle_count = r_cycle_cnt;
    assign o_stall_count = r_stall_cnt;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios plus random traffic, checked
// cycle by cycle against a mode-level reference model through an expected queue.
module tb_pipeline_sequencer;

    localparam int W = 1 + 4 + 4 + 1 + 1 + 32 + 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_step_req = 1'b0;
    logic [31:0] i_step_count = '0;
    logic        i_stop = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_taken = 1'b0;
    logic        i_halt_detect = 1'b0;
    logic        o_pc_en;
    logic [3:0]  o_latch_en;
    logic [3:0]  o_latch_flush;
    logic        o_busy;
    logic        o_halted;
    logic [31:0] o_cycle_count;
    logic [31:0] o_stall_count;
    logic [2:0]  o_dbg_state;

    logic        t4_start = 1'b0;
    logic [3:0]  t4_step_count = '0;
    logic        t4_pc_en;
    logic [3:0]  t4_latch_en;
    logic [3:0]  t4_latch_flush;
    logic        t4_busy;
    logic        t4_halted;
    logic [3:0]  t4_cycle;
    logic [3:0]  t4_stall;
    logic [2:0]  t4_dbg_state;

    logic [W-1:0] act_vec;
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    string       m_mode  = "idle";
    string       m_saved = "run";
    int          m_left  = 0;
    int          m_dleft = 0;
    logic [31:0] m_cyc   = '0;
    logic [31:0] m_stl   = '0;

    pipeline_sequencer u_dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_step_req(i_step_req), .i_step_count(i_step_count),
        .i_stop(i_stop), .i_stall(i_stall), .i_taken(i_taken), .i_halt_detect(i_halt_detect),
        .o_pc_en(o_pc_en), .o_latch_en(o_latch_en), .o_latch_flush(o_latch_flush),
        .o_busy(o_busy), .o_halted(o_halted),
        .o_cycle_count(o_cycle_count), .o_stall_count(o_stall_count),
        .o_dbg_state(o_dbg_state)
    );

    pipeline_sequencer #(.CNT_BITS(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .i_start(t4_start), .i_step_req(1'b0), .i_step_count(t4_step_count),
        .i_stop(1'b0), .i_stall(1'b0), .i_taken(1'b0), .i_halt_detect(1'b0),
        .o_pc_en(t4_pc_en), .o_latch_en(t4_latch_en), .o_latch_flush(t4_latch_flush),
        .o_busy(t4_busy), .o_halted(t4_halted),
        .o_cycle_count(t4_cycle), .o_stall_count(t4_stall),
        .o_dbg_state(t4_dbg_state)
    );

    assign act_vec = {o_pc_en, o_latch_en, o_latch_flush, o_busy, o_halted,
                      o_cycle_count, o_stall_count};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one call per clock cycle, outputs first, then the mode update.
    task automatic model_cycle(input logic st, input logic sr, input logic [31:0] cnt,
                               input logic sp, input logic sl, input logic tk, input logic hd);
        logic       pc, busy, hlt, adv, stall_inc;
        logic [3:0] en, fl;
        string      nxt;
        pc = 1'b0; en = 4'b0; fl = 4'b0; adv = 1'b0; stall_inc = 1'b0;
        busy = (m_mode == "run") || (m_mode == "step") || (m_mode == "drain");
        hlt  = (m_mode == "halted");
        nxt  = m_mode;
        if (m_mode == "idle") begin
            if (st) nxt = "run";
            else if (sr) begin
                nxt = "step";
                m_left = (cnt == 0) ? 1 : int'(cnt);
            end
        end else if ((m_mode == "run") || (m_mode == "step")) begin
            if (sp) nxt = "idle";
            else begin
                adv = 1'b1;
                if (tk) begin
                    pc = 1'b1; en = 4'b1111; fl = 4'b0111;
                end else if (sl) begin
                    en = 4'b1110; fl = 4'b0010; stall_inc = 1'b1;
                end else begin
                    pc = 1'b1; en = 4'b1111;
                end
                if (m_mode == "step") m_left--;
                if (!tk && !sl && hd) begin
                    m_saved = m_mode;
                    m_dleft = 4;
                    nxt = "drain";
                end else if ((m_mode == "step") && (m_left == 0)) begin
                    nxt = "idle";
                end
            end
        end else if (m_mode == "drain") begin
            adv = 1'b1;
            if (tk) begin
                pc = 1'b1; en = 4'b1111; fl = 4'b0111;
                if (m_saved == "run") nxt = "run";
                else nxt = (m_left == 0) ? "idle" : "step";
            end else begin
                en = 4'b1111; fl = 4'b0001;
                m_dleft--;
                if (m_dleft == 0) nxt = "halted";
            end
        end
        exp_q.push_back({pc, en, fl, busy, hlt, m_cyc, m_stl});
        if (adv && (m_cyc != 32'hFFFF_FFFF)) m_cyc++;
        if (stall_inc && (m_stl != 32'hFFFF_FFFF)) m_stl++;
        m_mode = nxt;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic drive(input logic st, input logic sr, input logic [31:0] cnt,
                         input logic sp, input logic sl, input logic tk, input logic hd);
        i_start = st; i_step_req = sr; i_step_count = cnt;
        i_stop = sp; i_stall = sl; i_taken = tk; i_halt_detect = hd;
        model_cycle(st, sr, cnt, sp, sl, tk, hd);
        @(posedge clk);
        #1;
        i_start = 1'b0; i_step_req = 1'b0; i_stop = 1'b0;
        i_stall = 1'b0; i_taken = 1'b0; i_halt_detect = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic do_reset();
        i_start = 1'b0; i_step_req = 1'b0; i_stop = 1'b0;
        i_stall = 1'b0; i_taken = 1'b0; i_halt_detect = 1'b0; t4_start = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", act_vec, '0);
        m_mode = "idle"; m_left = 0; m_dleft = 0; m_cyc = '0; m_stl = '0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_outputs", act_vec, e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin : stimulus
        @(posedge clk);
        #1;
        do_reset();

        // 4-bit counter saturation: 20 run cycles clip at 15
        t4_start = 1'b1;
        idle(1);
        t4_start = 1'b0;
        idle(20);
        check("sat4_cycle_count", W'(t4_cycle), W'(4'hF));
        check("sat4_busy", W'(t4_busy), W'(1'b1));

        // Step of 3, then step of 0 (one cycle)
        do_reset();
        drive(0, 1, 3, 0, 0, 0, 0);
        idle(5);
        check("step3_cycles", W'(o_cycle_count), W'(32'd3));
        check("step3_idle", W'(o_busy), W'(1'b0));
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(3);
        check("step0_cycles", W'(o_cycle_count), W'(32'd4));

        // Start + step together runs; stall; redirect with stall; halt drain
        drive(1, 1, 5, 0, 0, 0, 0);
        idle(8);
        check("start_wins_busy", W'(o_busy), W'(1'b1));
        drive(0, 0, 0, 0, 1, 0, 0);
        check("stall_count_1", W'(o_stall_count), W'(32'd1));
        drive(0, 0, 0, 0, 1, 1, 0);
        check("redirect_no_stall", W'(o_stall_count), W'(32'd1));
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(4);
        idle(2);
        check("halted_set", W'(o_halted), W'(1'b1));
        drive(1, 1, 2, 0, 0, 0, 0);
        idle(2);
        check("halted_holds", W'(o_halted), W'(1'b1));

        // Wrong-path halt: redirect on the second drain cycle
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        drive(0, 0, 0, 1, 1, 1, 0);
        idle(6);
        check("wrong_path_not_halted", W'(o_halted), W'(1'b0));
        check("wrong_path_busy", W'(o_busy), W'(1'b1));
        drive(0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // Step interrupted by a wrong-path halt resumes the remaining step
        drive(0, 1, 3, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(4);

        // Reset in the middle of a drain
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        do_reset();

        // Random traffic
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                      32'($urandom_range(0, 6)), $urandom_range(0, 29) == 0,
                      $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 24) == 0);
            end
        end

        @(negedge clk);
        #1;
        check("queue_drained", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
